axi4_mem_bridge: RTL and testbench

//  AXI4 slave endpoint directly downstream of the AXI4 N:1 crossbar mux. It terminates the muxed

---
 rtl/axi4_mem_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_axi4_mem_bridge.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_mem_bridge.sv
// ---------------------------------------------------------------------------
// axi4_mem_bridge
//   AXI4 slave endpoint that sits behind the N:1 AXI crossbar mux. It serves
//   one AXI transaction at a time and turns each INCR burst into a sequence
//   of single-beat requests on a simple valid/ready memory port. Reads and
//   writes contend in IDLE and are granted in strict alternation.
//
//   Optional feature macro: AXI4_MEM_BRIDGE_ERR_CHECK_EN
//     defined   : non-INCR bursts, narrow sizes and misplaced wlast mark the
//                 burst as errored. It still runs its full length, makes no
//                 memory access and returns SLVERR on every B/R response.
//     undefined : every burst is treated as full-width INCR, wlast is
//                 ignored and responses are always OKAY.
//
// Ports
//   clk_i, reset_i   clock, asynchronous active-high reset
//   s_axi4_bus_i     AXI master->slave bundle, packed MSB first:
//                    aw{id,addr,len[8],size[3],burst[2],lock,cache[4],
//                    prot[3],qos[4],region[4],valid}, wid, wdata, wstrb,
//                    wlast, wvalid, bready,
//                    ar{id,addr,len,size,burst,lock,cache,prot,qos,region,
//                    valid}, rready
//   s_axi4_bus_o     AXI slave->master bundle, packed MSB first:
//                    awready, wready, bid, bresp[2], bvalid, arready,
//                    rid, rdata, rresp[2], rlast, rvalid
//   mem_v_o/mem_w_o  memory request valid / write(1) or read(0)
//   mem_addr_o       word address (byte address with the lane bits dropped)
//   mem_data_o       write data, mem_mask_o byte-write enables
//   mem_ready_i      request accepted when mem_v_o & mem_ready_i
//   mem_v_i          read data valid (in order, >=1 cycle after the request)
//   mem_data_i       read data
//   debug_state_o    current FSM state encoding
//
// Handshakes: every channel (AXI and memory) transfers on the rising edge
// where valid and ready are both high. A valid, once raised, is held until
// that edge; valid never depends on ready, while ready may depend on valid.
// ---------------------------------------------------------------------------
module axi4_mem_bridge #(
  parameter int id_width_p   = 4,
  parameter int addr_width_p = 32,
  parameter int data_width_p = 64
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic [2*(id_width_p+addr_width_p+30)+id_width_p+data_width_p+data_width_p/8+4-1:0] s_axi4_bus_i,
  output logic [2*id_width_p+data_width_p+10-1:0] s_axi4_bus_o,
  output logic mem_v_o,
  output logic mem_w_o,
  output logic [addr_width_p-$clog2(data_width_p/8)-1:0] mem_addr_o,
  output logic [data_width_p-1:0] mem_data_o,
  output logic [data_width_p/8-1:0] mem_mask_o,
  input  logic mem_ready_i,
  input  logic mem_v_i,
  input  logic [data_width_p-1:0] mem_data_i,
  output logic [2:0] debug_state_o
);

  localparam int lg_bytes_lp   = $clog2(data_width_p/8);
  localparam int mem_addr_w_lp = addr_width_p - lg_bytes_lp;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    RD_DATA = 3'd5
  } state_e;

  // master -> slave fields
  logic [id_width_p-1:0]     awid, wid, arid;
  logic [addr_width_p-1:0]   awaddr, araddr;
  logic [7:0]                awlen, arlen;
  logic [2:0]                awsize, arsize, awprot, arprot;
  logic [1:0]                awburst, arburst;
  logic                      awlock, arlock;
  logic [3:0]                awcache, arcache, awqos, arqos, awregion, arregion;
  logic                      awvalid, arvalid, wvalid, wlast, bready, rready;
  logic [data_width_p-1:0]   wdata;
  logic [data_width_p/8-1:0] wstrb;

  // slave -> master fields
  logic                      awready, wready, bvalid, arready, rvalid, rlast;
  logic [1:0]                bresp, rresp;

  assign {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
          awregion, awvalid, wid, wdata, wstrb, wlast, wvalid, bready,
          arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
          arregion, arvalid, rready} = s_axi4_bus_i;

  // Fields the bridge deliberately ignores.
  logic unused_bits;
  assign unused_bits = ^{wid, awlock, awcache, awprot, awqos, awregion,
                         arlock, arcache, arprot, arqos, arregion,
                         awaddr, araddr, awburst, arburst, awsize, arsize, wlast};

  state_e                   state;
  logic                     awready_r, arready_r;
  logic                     prio_wr_r;
  logic [id_width_p-1:0]    id_r;
  logic [mem_addr_w_lp-1:0] addr_r;
  logic [7:0]               len_r, cnt_r;
  logic [data_width_p-1:0]  rdata_r;
  logic                     err_r;
  logic                     last_beat;

  localparam logic [mem_addr_w_lp-1:0] addr_one_lp = {{(mem_addr_w_lp-1){1'b0}}, 1'b1};

  assign last_beat = (cnt_r == len_r);

`ifndef AXI4_MEM_BRIDGE_ERR_CHECK_EN
  assign err_r = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= IDLE;
      awready_r <= 1'b0;
      arready_r <= 1'b0;
      prio_wr_r <= 1'b1;
      id_r      <= '0;
      addr_r    <= '0;
      len_r     <= '0;
      cnt_r     <= '0;
      rdata_r   <= '0;
`ifdef AXI4_MEM_BRIDGE_ERR_CHECK_EN
      err_r     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // The grant cycle raises a one-cycle ready; the address handshake
          // completes on the following edge, and only then do we move on.
          if (awready_r || arready_r) begin
            awready_r <= 1'b0;
            arready_r <= 1'b0;
            state     <= awready_r ? WR_DATA : RD_REQ;
          end else if (awvalid && (prio_wr_r || !arvalid)) begin
            awready_r <= 1'b1;
            prio_wr_r <= ~prio_wr_r;
            id_r      <= awid;
            addr_r    <= awaddr[addr_width_p-1:lg_bytes_lp];
            len_r     <= awlen;
            cnt_r     <= '0;
`ifdef AXI4_MEM_BRIDGE_ERR_CHECK_EN
            err_r     <= (awburst != 2'b01) || (awsize != 3'(lg_bytes_lp));
`endif
          end else if (arvalid) begin
            arready_r <= 1'b1;
            prio_wr_r <= ~prio_wr_r;
            id_r      <= arid;
            addr_r    <= araddr[addr_width_p-1:lg_bytes_lp];
            len_r     <= arlen;
            cnt_r     <= '0;
`ifdef AXI4_MEM_BRIDGE_ERR_CHECK_EN
            err_r     <= (arburst != 2'b01) || (arsize != 3'(lg_bytes_lp));
`endif
          end
        end
        WR_DATA: begin
          if (wvalid && wready) begin
            addr_r <= addr_r + addr_one_lp;
            cnt_r  <= cnt_r + 8'd1;
`ifdef AXI4_MEM_BRIDGE_ERR_CHECK_EN
            if (wlast != last_beat) err_r <= 1'b1;
`endif
            if (last_beat) state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bready) state <= IDLE;
        end
        RD_REQ: begin
          if (err_r || mem_ready_i) state <= RD_WAIT;
        end
        RD_WAIT: begin
          // Errored bursts never issued a request, so there is nothing to wait for.
          if (err_r) begin
            rdata_r <= '0;
            state   <= RD_DATA;
          end else if (mem_v_i) begin
            rdata_r <= mem_data_i;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rready) begin
            if (last_beat) begin
              state <= IDLE;
            end else begin
              cnt_r  <= cnt_r + 8'd1;
              addr_r <= addr_r + addr_one_lp;
              state  <= RD_REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write requests are tied combinationally to the W beat so a stalled memory
  // stalls the AXI master directly; errored bursts drain W without memory.
  assign awready = awready_r;
  assign arready = arready_r;
  assign wready  = (state == WR_DATA) && (mem_ready_i || err_r);
  assign bvalid  = (state == WR_RESP);
  assign rvalid  = (state == RD_DATA);
  assign rlast   = (state == RD_DATA) && last_beat;
  assign bresp   = err_r ? 2'b10 : 2'b00;
  assign rresp   = err_r ? 2'b10 : 2'b00;

  assign mem_v_o    = !err_r && (((state == WR_DATA) && wvalid) || (state == RD_REQ));
  assign mem_w_o    = (state == WR_DATA);
  assign mem_addr_o = addr_r;
  assign mem_data_o = wdata;
  assign mem_mask_o = wstrb;

  assign debug_state_o = state;

  assign s_axi4_bus_o = {awready, wready, id_r, bresp, bvalid, arready,
                         id_r, rdata_r, rresp, rlast, rvalid};

endmodule

// File: tb/tb_axi4_mem_bridge.sv
module tb_axi4_mem_bridge;

  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int MOSI_W = 2*(IDW+AW+30)+IDW+DW+DW/8+4;
  localparam int MISO_W = 2*IDW+DW+10;
  localparam int MAW = AW-3;
  localparam int TMO = 300;

`ifdef AXI4_MEM_BRIDGE_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_i;
  logic [MOSI_W-1:0] bus_i;
  logic [MISO_W-1:0] bus_o;
  logic mem_v_o, mem_w_o, mem_ready_i, mem_v_i;
  logic [MAW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o, mem_data_i;
  logic [DW/8-1:0] mem_mask_o;
  logic [2:0] debug_state;

  logic [IDW-1:0] awid, arid, bid, rid;
  logic [AW-1:0]  awaddr, araddr;
  logic [7:0]     awlen, arlen;
  logic [2:0]     awsize, arsize;
  logic [1:0]     awburst, arburst, bresp, rresp;
  logic           awvalid, arvalid, wvalid, wlast, bready, rready;
  logic [DW-1:0]  wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic           awready, wready, bvalid, arready, rvalid, rlast;

  assign bus_i = {awid, awaddr, awlen, awsize, awburst, 1'b1, 4'h3, 3'h5, 4'hA, 4'h6, awvalid,
                  4'h9, wdata, wstrb, wlast, wvalid, bready,
                  arid, araddr, arlen, arsize, arburst, 1'b1, 4'hC, 3'h2, 4'h5, 4'h9, arvalid, rready};
  assign {awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid} = bus_o;

  axi4_mem_bridge #(.id_width_p(IDW), .addr_width_p(AW), .data_width_p(DW)) dut (
    .clk_i(clk), .reset_i(reset_i), .s_axi4_bus_i(bus_i), .s_axi4_bus_o(bus_o),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_mask_o(mem_mask_o), .mem_ready_i(mem_ready_i), .mem_v_i(mem_v_i), .mem_data_i(mem_data_i),
    .debug_state_o(debug_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [103:0] exp_wr_q[$];   // {word addr(32), mask(8), data(64)}
  logic [63:0]  exp_rd_q[$];
  logic [63:0]  ref_mem [256];
  logic [63:0]  mod_mem [256];
  bit  ready_rnd = 1'b0;
  int  wr_cnt = 0, rd_cnt = 0;
  time aw_hs_time, ar_hs_time;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // memory model: samples at negedge, drives at posedge+1, 1-cycle read latency
  initial begin
    bit rd_pend = 1'b0;
    logic [7:0] rd_idx = '0;
    logic [103:0] e;
    mem_ready_i = 1'b1;
    mem_v_i = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk);
      if (mem_v_o && mem_ready_i) begin
        if (mem_w_o) begin
          wr_cnt++;
          for (int b = 0; b < 8; b++)
            if (mem_mask_o[b]) mod_mem[mem_addr_o[7:0]][b*8 +: 8] = mem_data_o[b*8 +: 8];
          if (exp_wr_q.size() == 0) begin
            check("unexpected_mem_write", 64'(mem_addr_o), 64'hFFFF_FFFF);
          end else begin
            e = exp_wr_q.pop_front();
            check("mem_wr_addr", 64'(mem_addr_o), 64'(e[103:72]));
            check("mem_wr_mask", 64'(mem_mask_o), 64'(e[71:64]));
            check("mem_wr_data", mem_data_o, e[63:0]);
          end
        end else begin
          rd_cnt++;
          rd_pend = 1'b1;
          rd_idx = mem_addr_o[7:0];
        end
      end
      @(posedge clk);
      #1;
      mem_v_i = rd_pend;
      mem_data_i = rd_pend ? mod_mem[rd_idx] : 64'(~$urandom);
      rd_pend = 1'b0;
      mem_ready_i = ready_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic axi_write(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [63:0] base, input bit stall, input bit exp_err);
    logic [MAW-1:0] wa;
    int n;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd3; awburst = burst; awvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (awready) break;
      if (++n > TMO) begin check("aw_timeout", 64'd1, 64'd0); break; end
      step();
    end
    aw_hs_time = $time;
    step();
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (stall && $urandom_range(0, 1) == 1) begin wvalid = 1'b0; step(); end
      wvalid = 1'b1; wdata = base + 64'(i); wstrb = 8'hFF; wlast = (i == int'(len));
      wa = addr[AW-1:3] + MAW'(i);
      if (!exp_err) begin
        exp_wr_q.push_back({32'(wa), 8'hFF, base + 64'(i)});
        ref_mem[wa[7:0]] = base + 64'(i);
      end
      n = 0;
      forever begin
        @(negedge clk);
        if (i == 0) check("awready_one_cycle", 64'(awready), 64'd0);
        if (wready) break;
        if (++n > TMO) begin check("w_timeout", 64'd1, 64'd0); break; end
        step();
      end
      step();
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bvalid && bready) break;
      if (++n > TMO) begin check("b_timeout", 64'd1, 64'd0); break; end
      step();
      bready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    check("bresp", 64'(bresp), exp_err ? 64'd2 : 64'd0);
    check("bid", 64'(bid), 64'(id));
    step();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input bit stall, input bit exp_err,
                          input int max_beats, input bit check_lat);
    logic [MAW-1:0] ra;
    logic [63:0] e;
    int n;
    for (int i = 0; i <= int'(len); i++) begin
      ra = addr[AW-1:3] + MAW'(i);
      exp_rd_q.push_back(exp_err ? 64'd0 : ref_mem[ra[7:0]]);
    end
    arid = id; araddr = addr; arlen = len; arsize = 3'd3; arburst = burst; arvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (arready) break;
      if (++n > TMO) begin check("ar_timeout", 64'd1, 64'd0); break; end
      step();
    end
    ar_hs_time = $time;
    step();
    arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      n = 0;
      forever begin
        @(negedge clk);
        n++;
        if (rvalid && rready) break;
        if (n > TMO) begin check("r_timeout", 64'd1, 64'd0); break; end
        step();
        rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (i == 0 && check_lat) check("ar_to_rvalid_cycles", 64'(n), 64'd3);
      e = (exp_rd_q.size() != 0) ? exp_rd_q.pop_front() : 64'hDEAD;
      check("rdata", rdata, e);
      check("rid", 64'(rid), 64'(id));
      check("rresp", 64'(rresp), exp_err ? 64'd2 : 64'd0);
      check("rlast", 64'(rlast), 64'(i == int'(len)));
      step();
      if (i + 1 == max_beats && i < int'(len)) begin
        rready = 1'b0;
        n = 0;
        forever begin
          @(negedge clk);
          if (rvalid) break;
          if (++n > TMO) begin check("r_abort_timeout", 64'd1, 64'd0); break; end
        end
        return;
      end
    end
    rready = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step(); step();
    reset_i = 1'b0;
    step();
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0;
    for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; mod_mem[i] = '0; end
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b0;
    wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0; rready = 1'b0;
    reset_i = 1'b1;
    step(); step();
    @(negedge clk);
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_mem_v", 64'(mem_v_o), 64'd0);
    check("rst_state", 64'(debug_state), 64'd0);
    step();
    reset_i = 1'b0;
    step();

    // 1: write burst 0x40 len 3 -> words 0x8..0xB
    w0 = wr_cnt;
    axi_write(4'h3, 32'h40, 8'd3, 2'b01, 64'hA, 1'b0, 1'b0);
    check("t1_wr_count", 64'(wr_cnt - w0), 64'd4);

    // 2: read it back, minimum latency
    axi_read(4'h5, 32'h40, 8'd3, 2'b01, 1'b0, 1'b0, 0, 1'b1);

    // 3: arbitration alternation from a fresh reset
    do_reset();
    fork
      axi_write(4'h1, 32'h200, 8'd0, 2'b01, 64'h1111, 1'b0, 1'b0);
      axi_read(4'h2, 32'h300, 8'd0, 2'b01, 1'b0, 1'b0, 0, 1'b0);
    join
    check("t3_write_first", 64'(aw_hs_time < ar_hs_time), 64'd1);
    axi_write(4'h4, 32'h208, 8'd0, 2'b01, 64'h2222, 1'b0, 1'b0);
    fork
      axi_write(4'h6, 32'h210, 8'd1, 2'b01, 64'h3333, 1'b0, 1'b0);
      axi_read(4'h7, 32'h200, 8'd1, 2'b01, 1'b0, 1'b0, 0, 1'b0);
    join
    check("t3_read_first", 64'(ar_hs_time < aw_hs_time), 64'd1);

    // 4: random memory and response stalls
    ready_rnd = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [7:0] l;
      l = 8'($urandom_range(1, 12));
      axi_write(4'(k), 32'h400 + 32'(k*256), l, 2'b01, 64'($urandom), 1'b1, 1'b0);
      axi_read(4'(k+8), 32'h400 + 32'(k*256), l, 2'b01, 1'b1, 1'b0, 0, 1'b0);
    end
    ready_rnd = 1'b0;
    step(); step();

    // 5: WRAP burst handling depends on error checking
    w0 = wr_cnt;
    axi_write(4'h9, 32'h100, 8'd1, 2'b10, 64'h5500, 1'b0, ERR_EN);
    check("t5_wr_count", 64'(wr_cnt - w0), ERR_EN ? 64'd0 : 64'd2);
    r0 = rd_cnt;
    axi_read(4'hA, 32'h100, 8'd1, 2'b10, 1'b0, ERR_EN, 0, 1'b0);
    check("t5_rd_count", 64'(rd_cnt - r0), ERR_EN ? 64'd0 : 64'd2);
    axi_read(4'hB, 32'h100, 8'd1, 2'b01, 1'b0, 1'b0, 0, 1'b0);

    // 6: reset in the middle of a read burst (after two beats)
    axi_read(4'hC, 32'h40, 8'd3, 2'b01, 1'b0, 1'b0, 2, 1'b0);
    reset_i = 1'b1;
    #1;
    check("t6_rvalid", 64'(rvalid), 64'd0);
    check("t6_mem_v", 64'(mem_v_o), 64'd0);
    check("t6_arready", 64'(arready), 64'd0);
    check("t6_wready", 64'(wready), 64'd0);
    check("t6_state", 64'(debug_state), 64'd0);
    exp_rd_q.delete();
    step();
    reset_i = 1'b0;
    step();
    axi_read(4'hD, 32'h40, 8'd3, 2'b01, 1'b0, 1'b0, 0, 1'b1);

    step(); step();
    check("wr_queue_drained", 64'(exp_wr_q.size()), 64'd0);
    check("rd_queue_drained", 64'(exp_rd_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
